// File: rtl/demux_1to2_80bit.sv
// Buffered 1-to-2 stream demultiplexer with a private FIFO per output channel.
// Select steers each accepted input word into channel 0 or channel 1.
module demux_1to2_80bit #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] In,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic             Select,
  output logic [WIDTH-1:0] Out0,
  output logic             Out0_valid,
  input  logic             Out0_ready,
  output logic [WIDTH-1:0] Out1,
  output logic             Out1_valid,
  input  logic             Out1_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem0 [DEPTH];
  logic [WIDTH-1:0] mem1 [DEPTH];
  logic [AW-1:0]    wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
  logic [AW:0]      count0, count1;
  logic             full0, full1;
  logic             push0, push1, pop0, pop1;

  assign full0 = (count0 == FULL);
  assign full1 = (count1 == FULL);

  // An unknown Select accepts nothing and reports an unknown ready.
  always_comb begin
    In_ready = 1'b0;
    push0    = 1'b0;
    push1    = 1'b0;
    case (Select)
      1'b0: begin
        In_ready = !full0;
        push0    = In_valid && !full0;
      end
      1'b1: begin
        In_ready = !full1;
        push1    = In_valid && !full1;
      end
      default: In_ready = 1'bx;
    endcase
  end

  assign Out0_valid = (count0 != '0);
  assign Out1_valid = (count1 != '0);
  assign pop0       = Out0_valid && Out0_ready;
  assign pop1       = Out1_valid && Out1_ready;
  assign Out0       = Out0_valid ? mem0[rd_ptr0] : '0;
  assign Out1       = Out1_valid ? mem1[rd_ptr1] : '0;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      wr_ptr0 <= '0;
      rd_ptr0 <= '0;
      count0  <= '0;
      wr_ptr1 <= '0;
      rd_ptr1 <= '0;
      count1  <= '0;
    end else begin
      if (push0) wr_ptr0 <= wr_ptr0 + 1'b1;
      if (pop0)  rd_ptr0 <= rd_ptr0 + 1'b1;
      if (push1) wr_ptr1 <= wr_ptr1 + 1'b1;
      if (pop1)  rd_ptr1 <= rd_ptr1 + 1'b1;
      case ({push0, pop0})
        2'b10:   count0 <= count0 + 1'b1;
        2'b01:   count0 <= count0 - 1'b1;
        default: count0 <= count0;
      endcase
      case ({push1, pop1})
        2'b10:   count1 <= count1 + 1'b1;
        2'b01:   count1 <= count1 - 1'b1;
        default: count1 <= count1;
      endcase
    end
  end

  // Storage needs no reset: the counts gate every read.
  always_ff @(posedge Clock) begin
    if (Reset_n && push0) mem0[wr_ptr0] <= In;
    if (Reset_n && push1) mem1[wr_ptr1] <= In;
  end

endmodule

// File: tb/tb_demux_1to2_80bit.sv
// Scoreboard bench for demux_1to2_80bit: a driver records accepted words per channel,
// and a monitor compares every channel output against those per-channel queues.
module tb_demux_1to2_80bit;

  localparam int WIDTH = 80;
  localparam int DEPTH = 2;

  logic             Clock;
  logic             Reset_n;
  logic [WIDTH-1:0] In;
  logic             In_valid;
  logic             In_ready;
  logic             Select;
  logic [WIDTH-1:0] Out0;
  logic             Out0_valid;
  logic             Out0_ready;
  logic [WIDTH-1:0] Out1;
  logic             Out1_valid;
  logic             Out1_ready;

  demux_1to2_80bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .In(In), .In_valid(In_valid), .In_ready(In_ready), .Select(Select),
    .Out0(Out0), .Out0_valid(Out0_valid), .Out0_ready(Out0_ready),
    .Out1(Out1), .Out1_valid(Out1_valid), .Out1_ready(Out1_ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } entry_t;

  entry_t sbq0[$];
  entry_t sbq1[$];
  int     cyc    = 0;
  int     checks = 0;
  int     passes = 0;
  bit     armed  = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle of inputs; a word is accepted when its channel holds fewer than DEPTH words.
  task automatic applyStimulus(input bit rstn, input bit vld, input bit sel,
                               input logic [WIDTH-1:0] data, input bit r0, input bit r1,
                               output bit acc);
    bit     expRdy;
    entry_t e;
    @(negedge Clock);
    Reset_n    = rstn;
    In_valid   = vld;
    Select     = sel;
    In         = data;
    Out0_ready = r0;
    Out1_ready = r1;
    #1;
    acc = 1'b0;
    if (armed) begin
      expRdy = ((sel ? sbq1.size() : sbq0.size()) != DEPTH);
      check("in_ready", WIDTH'(In_ready), WIDTH'(expRdy));
      if (rstn && vld && expRdy) begin
        acc    = 1'b1;
        e.data = data;
        e.cyc  = cyc;
        if (sel) sbq1.push_back(e);
        else     sbq0.push_back(e);
      end
    end
  endtask

  // A word accepted before the latest edge is in its FIFO; the oldest one must be shown.
  task automatic checkOutput(input int ch, input logic v, input logic [WIDTH-1:0] d, input logic r);
    entry_t head;
    bit     expV;
    int     n;
    n = ch ? sbq1.size() : sbq0.size();
    head.data = '0;
    head.cyc  = 0;
    if (n > 0) head = ch ? sbq1[0] : sbq0[0];
    expV = (n > 0) && (head.cyc < cyc);
    check($sformatf("out%0d_valid", ch), WIDTH'(v), WIDTH'(expV));
    check($sformatf("out%0d_data", ch), d, expV ? head.data : '0);
    if (expV && v && r) begin
      if (ch) void'(sbq1.pop_front());
      else    void'(sbq0.pop_front());
    end
  endtask

  always @(negedge Clock) begin
    #2;
    if (armed) begin
      checkOutput(0, Out0_valid, Out0, Out0_ready);
      checkOutput(1, Out1_valid, Out1, Out1_ready);
      if (!Reset_n) begin
        sbq0.delete();
        sbq1.delete();
      end
    end
  end

  initial begin
    bit               acc;
    logic [WIDTH-1:0] w;
    int               idx;
    Reset_n    = 1'b0;
    In_valid   = 1'b1;
    Select     = 1'b0;
    In         = '0;
    Out0_ready = 1'b0;
    Out1_ready = 1'b0;
    @(posedge Clock);
    #1 armed = 1'b1;

    // Reset held with a valid input, then simple steering to both channels.
    applyStimulus(1'b0, 1'b1, 1'b0, 80'h5, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, 80'h1, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 1'b1, 80'h2, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 1'b1, acc);

    // Channel 0 fills while channel 1 keeps accepting.
    applyStimulus(1'b1, 1'b1, 1'b0, 80'hA, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, 80'hB, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, 80'hC, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 1'b1, 80'hD, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, 80'hC, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, 80'hC, 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 1'b1, acc);

    // Pointer wrap on channel 1 with a toggling sink.
    idx = 0;
    for (int k = 0; k < 40 && idx < 8; k++) begin
      w = 80'h10 + WIDTH'(idx);
      applyStimulus(1'b1, 1'b1, 1'b1, w, 1'b1, (k % 2) == 0, acc);
      if (acc) idx++;
    end
    check("wrap_accepted", WIDTH'(idx), WIDTH'(8));
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 1'b1, acc);

    // Push and pop together on channel 0 at one word held.
    applyStimulus(1'b1, 1'b1, 1'b0, 80'h21, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, 80'h22, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 1'b0, 80'h0, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 1'b1, acc);

    // Reset with both channels full; nothing stale may return.
    applyStimulus(1'b1, 1'b1, 1'b0, 80'h31, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, 80'h32, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 1'b1, 80'h33, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 1'b1, 80'h34, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, 80'h0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, 80'h41, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 1'b1, 80'h42, 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 1'b1, acc);

    // Random traffic with occasional resets and sink stalls.
    for (int i = 0; i < 600; i++) begin
      w = {16'($urandom), $urandom, $urandom};
      applyStimulus($urandom_range(63) != 0, $urandom_range(3) != 0, 1'($urandom),
                    w, $urandom_range(2) != 0, $urandom_range(2) != 0, acc);
    end

    for (int i = 0; i < 40 && (sbq0.size() + sbq1.size()) != 0; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 1'b0, 80'h0, 1'b1, 1'b1, acc);
    check("drain_empty", WIDTH'(sbq0.size() + sbq1.size()), '0);

    @(negedge Clock);
    #5;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
